// File: rtl/conv_mac_pkg.sv
// Shared Q-format constants and helpers for the conv MAC array.
// round_sat works at a fixed wide internal width so that any lane
// configuration up to 64-bit accumulators / 32-bit results can use it.
package conv_mac_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 8;
    localparam int DEF_ACC_WIDTH  = 40;

    // Internal working widths of the rounding/saturation helper
    localparam int RS_ACC_W  = 64;
    localparam int RS_DATA_W = 32;

    typedef logic signed [RS_ACC_W-1:0] rs_acc_t;

    typedef struct packed {
        logic                 sat;
        logic [RS_DATA_W-1:0] value;
    } rs_result_t;

    // Largest representable signed result for a given width
    function automatic rs_acc_t sat_hi(input int data_width);
        return (64'sd1 <<< (data_width - 1)) - 64'sd1;
    endfunction

    // Smallest representable signed result for a given width
    function automatic rs_acc_t sat_lo(input int data_width);
        return -(64'sd1 <<< (data_width - 1));
    endfunction

    // Round half up (arithmetic), shift out the fraction, clamp to data_width
    function automatic rs_result_t round_sat(input rs_acc_t acc,
                                             input int      frac_bits,
                                             input int      data_width);
        rs_acc_t    r;
        rs_result_t res;
        r = acc;
        if (frac_bits > 0) begin
            r = r + (64'sd1 <<< (frac_bits - 1));
        end
        r = r >>> frac_bits;
        res.sat = 1'b0;
        if (r > sat_hi(data_width)) begin
            r       = sat_hi(data_width);
            res.sat = 1'b1;
        end else if (r < sat_lo(data_width)) begin
            r       = sat_lo(data_width);
            res.sat = 1'b1;
        end
        res.value = r[RS_DATA_W-1:0];
        return res;
    endfunction

    // LSB position of a lane inside a packed lane vector
    function automatic int lane_lsb(input int lane, input int data_width);
        return lane * data_width;
    endfunction

endpackage

// File: rtl/conv_mac_array_if.sv
// Stream interface of the conv MAC array: tap input and result output,
// each with its own valid/ready pair.
interface conv_mac_array_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_LANES  = 4
);
    logic                            in_valid;
    logic                            in_ready;
    logic [DATA_WIDTH-1:0]           in_act;
    logic [NUM_LANES*DATA_WIDTH-1:0] in_wgt;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_LANES*DATA_WIDTH-1:0] out_data;
    logic [NUM_LANES-1:0]            out_sat;

    // Upstream/downstream environment side
    modport master (
        output in_valid, in_act, in_wgt, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    // MAC array side
    modport slave (
        input  in_valid, in_act, in_wgt, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/conv_mac_lane.sv
// One MAC lane: S1 product register, S2 accumulator, and the combinational
// round/saturate of the S2 sum. Optional macro CONV_MAC_RELU_EN forces
// negative results to zero after saturation (sat flag is unaffected).
module conv_mac_lane
    import conv_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_advance,
    input  logic                         i_s1_valid,
    input  logic                         i_s1_first,
    input  logic signed [DATA_WIDTH-1:0] i_act,
    input  logic signed [DATA_WIDTH-1:0] i_wgt,
    output logic signed [DATA_WIDTH-1:0] o_result,
    output logic                         o_sat
);

    logic signed [2*DATA_WIDTH-1:0] w_act_ext;
    logic signed [2*DATA_WIDTH-1:0] w_wgt_ext;
    logic signed [2*DATA_WIDTH-1:0] r_prod;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH-1:0]    w_sum;
    rs_result_t                     w_rs;

    assign w_act_ext = (2*DATA_WIDTH)'(i_act);
    assign w_wgt_ext = (2*DATA_WIDTH)'(i_wgt);

    // S1: full-precision product; the shared valid bit lives in the top
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
        end else if (i_advance) begin
            r_prod <= w_act_ext * w_wgt_ext;
        end
    end

    // First tap of a frame loads instead of adding, so no clear cycle is needed
    assign w_prod_ext = ACC_WIDTH'(r_prod);
    assign w_sum      = i_s1_first ? w_prod_ext : (r_acc + w_prod_ext);

    // S2: accumulate only real taps; bubbles leave the sum untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_advance && i_s1_valid) begin
            r_acc <= w_sum;
        end
    end

    assign w_rs  = round_sat(RS_ACC_W'(w_sum), FRAC_BITS, DATA_WIDTH);
    assign o_sat = w_rs.sat;

`ifdef CONV_MAC_RELU_EN
    assign o_result = w_rs.value[DATA_WIDTH-1] ? '0 : w_rs.value[DATA_WIDTH-1:0];
`else
    assign o_result = w_rs.value[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/conv_mac_array.sv
// NUM_LANES parallel MAC lanes sharing one activation stream. Holds the tap
// counter, pipeline control bits, handshake and the output register.
// Optional macro CONV_MAC_RELU_EN (see conv_mac_lane) clamps negatives to 0.
module conv_mac_array
    import conv_mac_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS,
    parameter int NUM_LANES  = 4,
    parameter int KERNEL_LEN = 3,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    conv_mac_array_if.slave   bus
);

    localparam int CNT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KERNEL_LEN - 1);

    logic             w_stall;
    logic             w_advance;
    logic             w_accept;
    logic             w_first;
    logic             w_last;
    logic             w_load;
    logic [CNT_W-1:0] r_cnt;
    logic             r_s1_valid;
    logic             r_s1_first;
    logic             r_s1_last;
    logic             r_out_valid;

    // The whole pipeline freezes while a result waits for the consumer
    assign w_stall      = r_out_valid & ~bus.out_ready;
    assign w_advance    = ~w_stall;
    assign w_accept     = bus.in_valid & w_advance;
    assign w_first      = (r_cnt == '0);
    assign w_last       = (r_cnt == CNT_LAST);
    assign w_load       = w_advance & r_s1_valid & r_s1_last;
    assign bus.in_ready = w_advance;
    assign bus.out_valid = r_out_valid;

    // Tap position within the current frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last ? '0 : (r_cnt + 1'b1);
        end
    end

    // S1 control bits travel alongside the lane products
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= w_accept;
            r_s1_first <= w_first;
            r_s1_last  <= w_last;
        end
    end

    // Result valid: a new load wins over the consumer draining the old one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    logic [DATA_WIDTH-1:0] r_out_data [NUM_LANES];
    logic                  r_out_sat  [NUM_LANES];

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic signed [DATA_WIDTH-1:0] w_result;
        logic                         w_sat;

        conv_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .FRAC_BITS  (FRAC_BITS),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .i_advance  (w_advance),
            .i_s1_valid (r_s1_valid),
            .i_s1_first (r_s1_first),
            .i_act      (bus.in_act),
            .i_wgt      (bus.in_wgt[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH]),
            .o_result   (w_result),
            .o_sat      (w_sat)
        );

        // Per-lane output register, loaded when a frame's last tap leaves S2
        always_ff @(posedge clk) begin
            if (rst) begin
                r_out_data[gi] <= '0;
                r_out_sat[gi]  <= 1'b0;
            end else if (w_load) begin
                r_out_data[gi] <= w_result;
                r_out_sat[gi]  <= w_sat;
            end
        end

        assign bus.out_data[lane_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] = r_out_data[gi];
        assign bus.out_sat[gi] = r_out_sat[gi];
    end

endmodule

// File: tb/tb_conv_mac_array.sv
// Scoreboard bench for conv_mac_array (2 lanes, 3 taps, Q8.8).
module tb_conv_mac_array;

    localparam int DW = 16;
    localparam int FB = 8;
    localparam int NL = 2;
    localparam int KL = 3;
    localparam int AW = 40;

    typedef struct packed {
        logic [NL*DW-1:0] data;
        logic [NL-1:0]    sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_mac_array_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus();

    conv_mac_array #(
        .DATA_WIDTH (DW),
        .FRAC_BITS  (FB),
        .NUM_LANES  (NL),
        .KERNEL_LEN (KL),
        .ACC_WIDTH  (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_push  = 0;
    int   n_rx    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic push_exp(input logic [15:0] l0, input logic [15:0] l1, input logic [1:0] sat);
        exp_t e;
        e.data = {l1, l0};
        e.sat  = sat;
        sb_q.push_back(e);
        n_push++;
    endtask

    // Present one tap and hold it until accepted; returns just after the accepting edge
    task automatic send_tap(input logic [15:0] a, input logic [15:0] w0, input logic [15:0] w1);
        int guard;
        bus.in_valid = 1'b1;
        bus.in_act   = a;
        bus.in_wgt   = {w1, w0};
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready) begin
            guard++;
            if (guard > 200) begin
                $display("FAIL tap_timeout: in_ready got 0, required 1");
                $fatal(1, "tap accept timeout");
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic basic_frame();
        send_tap(16'h0100, 16'h0200, 16'hFF00);
        send_tap(16'h0100, 16'h0200, 16'hFF00);
        send_tap(16'h0100, 16'h0200, 16'hFF00);
    endtask

    task automatic round_frame();
        send_tap(16'h0001, 16'h0080, 16'hFF80);
        send_tap(16'h0000, 16'h0000, 16'h0000);
        send_tap(16'h0000, 16'h0000, 16'h0000);
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check(name, 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: every accepted result vector is compared with the oldest expectation
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            exp_t e;
            n_rx++;
            $display("txn %0d: lane0=0x%04h lane1=0x%04h sat=%b", n_rx,
                     bus.out_data[15:0], bus.out_data[31:16], bus.out_sat);
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_result: got 0x%08h, required no output", bus.out_data);
            end else begin
                e = sb_q.pop_front();
                check("out_data", 64'(bus.out_data), 64'(e.data));
                check("out_sat",  64'(bus.out_sat),  64'(e.sat));
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_act    = '0;
        bus.in_wgt    = '0;
        bus.out_ready = 1'b1;

        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_sat",   64'(bus.out_sat),   64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        @(posedge clk);
        #1;

        // Basic frame with latency check
        push_exp(16'h0600, 16'hFD00, 2'b00);
        basic_frame();
        @(negedge clk);
        check("lat_t1_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_t2_valid", 64'(bus.out_valid), 64'd1);
        drain("basic_drain");

        // Rounding
        @(posedge clk); #1;
        push_exp(16'h0001, 16'h0000, 2'b00);
        round_frame();
        drain("round_drain");

        // Saturation
        @(posedge clk); #1;
`ifdef CONV_MAC_RELU_EN
        push_exp(16'h7FFF, 16'h0000, 2'b11);
`else
        push_exp(16'h7FFF, 16'h8000, 2'b11);
`endif
        send_tap(16'h7FFF, 16'h7FFF, 16'h8001);
        send_tap(16'h7FFF, 16'h7FFF, 16'h8001);
        send_tap(16'h7FFF, 16'h7FFF, 16'h8001);
        drain("sat_drain");

        // Backpressure with streaming input
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        push_exp(16'h0600, 16'hFD00, 2'b00);
        push_exp(16'h0001, 16'h0000, 2'b00);
        fork
            begin
                basic_frame();
                round_frame();
            end
            begin
                int guard;
                guard = 0;
                @(negedge clk);
                while (!bus.out_valid && guard < 50) begin
                    @(negedge clk);
                    guard++;
                end
                check("bp_valid_seen", 64'(bus.out_valid), 64'd1);
                for (int i = 0; i < 5; i++) begin
                    check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                    check("bp_hold_data", 64'(bus.out_data), 64'h0000_0000_FD00_0600);
                    check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
                    @(negedge clk);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain("bp_drain");

        // Reset in the middle of a frame
        @(posedge clk); #1;
        send_tap(16'h0300, 16'h0100, 16'h0100);
        send_tap(16'h0300, 16'h0100, 16'h0100);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        push_exp(16'h0600, 16'hFD00, 2'b00);
        basic_frame();
        drain("midrst_drain");

        repeat (5) @(negedge clk);
        check("result_count", 64'(n_rx), 64'(n_push));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
